// File: rtl/adder_arbiter_if.sv
// Bus bundle for adder_arbiter: two requester ports, the shared adder hookup
// and the result/handshake channel.
interface adder_arbiter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             gnt0;

  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt1;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_c;

  logic [WIDTH:0]   result;
  logic             result_id;
  logic             result_valid;
  logic             result_ready;

  // Arbiter side
  modport slave (
    input  req0, a0, b0, req1, a1, b1, add_c, result_ready,
    output gnt0, gnt1, add_a, add_b, result, result_id, result_valid
  );

  // Requester / adder / consumer side
  modport master (
    output req0, a0, b0, req1, a1, b1, add_c, result_ready,
    input  gnt0, gnt1, add_a, add_b, result, result_id, result_valid
  );

endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external signed adder between two requesters;
// one operation in flight at a time (IDLE -> CALC -> DONE).
module adder_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  adder_arbiter_if.slave bus
);

  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             valid_q, valid_d;
  logic             result_id_q, result_id_d;
  logic [SW-1:0]    result_q, result_d;
  logic             win;

  // State and datapath registers; last_q resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      valid_q     <= 1'b0;
      result_id_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      valid_q     <= valid_d;
      result_id_q <= result_id_d;
      result_q    <= result_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    valid_d     = valid_q;
    result_id_d = result_id_q;
    result_d    = result_q;
    win         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          op_a_d  = win ? bus.a1 : bus.a0;
          op_b_d  = win ? bus.b1 : bus.b0;
          id_d    = win;
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = CALC;
        end
      end
      CALC: begin
        result_d    = bus.add_c;
        result_id_d = id_q;
        valid_d     = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.add_a        = op_a_q;
  assign bus.add_b        = op_b_q;
  assign bus.result       = result_q;
  assign bus.result_id    = result_id_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios, then randomized
// traffic scored against a transaction-level model of the arbitration rules.
module tb_adder_arbiter;

  typedef struct packed {
    logic       id;
    logic [4:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  adder_arbiter_if #(.WIDTH(4)) bus ();

  adder_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Shared signed adder
  assign bus.add_c = {bus.add_a[3], bus.add_a} + {bus.add_b[3], bus.add_b};

  always #5 clk = ~clk;

  // Reference model state
  bit   model_last;
  bit   idle_flag;
  bit   prev_valid;
  bit   prev_gnt;
  logic [4:0] held_result;
  logic       held_id;
  exp_t exp_q[$];

  function automatic logic [4:0] ssum(input logic [3:0] a, input logic [3:0] b);
    return {a[3], a} + {b[3], b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated operation from a single requester, with two cycles of backpressure
  task automatic run_single(input bit id, input logic [3:0] a, input logic [3:0] b,
                            input logic [4:0] exp_sum);
    if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else    begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
    bus.result_ready = 1'b0;
    cyc();
    chk("single_gnt0", bus.gnt0, !id);
    chk("single_gnt1", bus.gnt1, id);
    chk("single_add_a", bus.add_a, a);
    chk("single_add_b", bus.add_b, b);
    chk("single_valid_early", bus.result_valid, 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cyc();
    chk("single_gnt_pulse", bus.gnt0 | bus.gnt1, 0);
    chk("single_valid", bus.result_valid, 1);
    chk("single_result", bus.result, exp_sum);
    chk("single_id", bus.result_id, id);
    cyc();
    chk("single_hold_valid", bus.result_valid, 1);
    chk("single_hold_result", bus.result, exp_sum);
    bus.result_ready = 1'b1;
    cyc();
    chk("single_accept_valid", bus.result_valid, 0);
    chk("single_keep_result", bus.result, exp_sum);
    chk("single_keep_id", bus.result_id, id);
    bus.result_ready = 1'b0;
    model_last = id;
  endtask

  // One cycle of random traffic, scored at the negedge after each active edge
  task automatic rnd_cycle(input bit allow_new);
    logic s_r0, s_r1, s_rdy, g0, g1, v;
    bit   w;
    exp_t e;
    @(posedge clk);
    s_r0  = bus.req0;
    s_r1  = bus.req1;
    s_rdy = bus.result_ready;
    @(negedge clk);
    g0 = bus.gnt0;
    g1 = bus.gnt1;
    v  = bus.result_valid;
    chk("rnd_excl", g0 & g1, 0);
    chk("rnd_gnt", g0 | g1, idle_flag && (s_r0 || s_r1));
    if (g0 || g1) begin
      w = (s_r0 && s_r1) ? !model_last : s_r1;
      chk("rnd_winner", g1, w);
      e.id  = w;
      e.sum = w ? ssum(bus.a1, bus.b1) : ssum(bus.a0, bus.b0);
      exp_q.push_back(e);
      model_last = w;
      idle_flag  = 1'b0;
      if (w) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
    end
    if (!prev_valid) begin
      chk("rnd_valid_rise", v, prev_gnt);
      if (v) begin
        chk("rnd_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rnd_result", bus.result, e.sum);
          chk("rnd_id", bus.result_id, e.id);
        end
      end
    end else if (!s_rdy) begin
      chk("rnd_stall_valid", v, 1);
      chk("rnd_stall_result", bus.result, held_result);
      chk("rnd_stall_id", bus.result_id, held_id);
    end else begin
      chk("rnd_accept", v, 0);
      idle_flag = 1'b1;
    end
    prev_valid  = v;
    prev_gnt    = g0 | g1;
    held_result = bus.result;
    held_id     = bus.result_id;
    if (!bus.req0) begin
      bus.a0 = 4'($urandom);
      bus.b0 = 4'($urandom);
      if (allow_new && $urandom_range(0, 2) == 0) bus.req0 = 1'b1;
    end
    if (!bus.req1) begin
      bus.a1 = 4'($urandom);
      bus.b1 = 4'($urandom);
      if (allow_new && $urandom_range(0, 2) == 0) bus.req1 = 1'b1;
    end
    bus.result_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   w;
    bit   cur;
    n_rst = 1'b0;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    bus.result_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_id", bus.result_id, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_b", bus.add_b, 0);
    n_rst = 1'b1;

    // Single ops and extremes
    run_single(1'b0, 4'(-6), 4'(-6), 5'b10100);
    run_single(1'b1, 4'(-8), 4'(-8), 5'b10000);
    run_single(1'b0, 4'(7),  4'(7),  5'b01110);
    run_single(1'b0, 4'(-8), 4'(7),  5'b11111);

    // Tie with both requests held: alternating grants, one result per 3 cycles
    bus.a0 = 4'(3);  bus.b0 = 4'(2);
    bus.a1 = 4'(-4); bus.b1 = 4'(-1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.result_ready = 1'b1;
    w   = !model_last;
    cur = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i % 3 == 0) begin
        chk("tie_gnt0", bus.gnt0, !w);
        chk("tie_gnt1", bus.gnt1, w);
        cur = w;
        w   = !w;
      end else if (i % 3 == 1) begin
        chk("tie_gnt_off", bus.gnt0 | bus.gnt1, 0);
        chk("tie_valid", bus.result_valid, 1);
        chk("tie_result", bus.result, cur ? ssum(bus.a1, bus.b1) : ssum(bus.a0, bus.b0));
        chk("tie_id", bus.result_id, cur);
      end else begin
        chk("tie_gnt_off", bus.gnt0 | bus.gnt1, 0);
        chk("tie_valid_low", bus.result_valid, 0);
      end
    end
    model_last = cur;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.result_ready = 1'b0;

    // Backpressure with requester 1 pending
    bus.req0 = 1'b1; bus.a0 = 4'(5); bus.b0 = 4'(-3);
    cyc();
    chk("bp_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 4'(-7); bus.b1 = 4'(2);
    cyc();
    chk("bp_valid", bus.result_valid, 1);
    chk("bp_result", bus.result, 5'b00010);
    chk("bp_no_gnt1", bus.gnt1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_stall_valid", bus.result_valid, 1);
      chk("bp_stall_result", bus.result, 5'b00010);
      chk("bp_stall_gnt1", bus.gnt1, 0);
    end
    bus.result_ready = 1'b1;
    cyc();
    chk("bp_accept_valid", bus.result_valid, 0);
    chk("bp_accept_gnt1", bus.gnt1, 0);
    bus.result_ready = 1'b0;
    cyc();
    chk("bp_gnt1", bus.gnt1, 1);
    bus.req1 = 1'b0;
    cyc();
    chk("bp2_valid", bus.result_valid, 1);
    chk("bp2_result", bus.result, 5'b11011);
    chk("bp2_id", bus.result_id, 1);
    bus.result_ready = 1'b1;
    cyc();
    chk("bp2_accept", bus.result_valid, 0);
    bus.result_ready = 1'b0;

    // Reset during CALC, then a tie must go to requester 0
    bus.req0 = 1'b1; bus.a0 = 4'(3); bus.b0 = 4'(4);
    cyc();
    chk("mid_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_gnt0", bus.gnt0, 0);
    chk("mid_rst_gnt1", bus.gnt1, 0);
    chk("mid_rst_valid", bus.result_valid, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_id", bus.result_id, 0);
    chk("mid_rst_add_a", bus.add_a, 0);
    chk("mid_rst_add_b", bus.add_b, 0);
    cyc();
    chk("mid_rst_hold_valid", bus.result_valid, 0);
    bus.req0 = 1'b1; bus.a0 = 4'(-3); bus.b0 = 4'(5);
    bus.req1 = 1'b1; bus.a1 = 4'(1);  bus.b1 = 4'(1);
    n_rst = 1'b1;
    cyc();
    chk("post_rst_gnt0", bus.gnt0, 1);
    chk("post_rst_gnt1", bus.gnt1, 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc();
    chk("post_rst_valid", bus.result_valid, 1);
    chk("post_rst_result", bus.result, 5'b00010);
    chk("post_rst_id", bus.result_id, 0);
    bus.result_ready = 1'b1;
    cyc();
    chk("post_rst_accept", bus.result_valid, 0);
    bus.result_ready = 1'b0;
    model_last = 1'b0;

    // Random traffic
    idle_flag   = 1'b1;
    prev_valid  = 1'b0;
    prev_gnt    = 1'b0;
    held_result = bus.result;
    held_id     = bus.result_id;
    for (int i = 0; i < 1000; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 40; i++) rnd_cycle(1'b0);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_reqs", bus.req0 | bus.req1, 0);
    chk("drain_valid", bus.result_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
